// File: rtl/eth_pcs_rx_block_assembler_pkg.sv
// Shared PCS constants, sync-header codes and the block-assembler state type.
package eth_pcs_params;

  localparam int W_DATA  = 32;
  localparam int W_SYNC  = 2;
  localparam int W_BLK   = 2 * W_DATA;
  localparam int W_SCR   = 58;
  localparam int SCR_TAP = 39;

  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  typedef enum logic {
    WAIT_HDR,
    HAVE_LOW
  } asm_state_t;

  // Only 01 and 10 are legal sync headers.
  function automatic logic hdr_is_bad(input logic [W_SYNC-1:0] hdr);
    return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
  endfunction

endpackage

// File: rtl/eth_pcs_rx_block_assembler_descrambler.sv
// Self-synchronising x^58+x^39+1 descrambler, W bits per valid cycle, bit 0 first.
module eth_pcs_rx_descrambler
  import eth_pcs_params::*;
#(
  parameter int W = W_DATA
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [W_SCR-1:0] state_q;
  logic [W_SCR-1:0] state_d;

  // The register is fed with the received (scrambled) bit, which is what
  // makes the descrambler recover by itself after W_SCR clean bits.
  always_comb begin
    state_d = state_q;
    o_data  = '0;
    for (int i = 0; i < W; i++) begin
      o_data[i] = i_data[i] ^ state_d[SCR_TAP-1] ^ state_d[W_SCR-1];
      state_d   = {state_d[W_SCR-2:0], i_data[i]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= '0;
    end else if (i_valid) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/eth_pcs_rx_block_assembler.sv
// Descrambles gearbox words and pairs them into 66-bit blocks while lock is held.
// Optional saturating error counters: define ETH_PCS_RX_ASM_ERR_CNT_EN.
module eth_pcs_rx_block_assembler
  import eth_pcs_params::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx_lock,
  input  logic              i_grbx_hdr_valid,
  input  logic [W_SYNC-1:0] i_grbx_hdr,
  input  logic              i_grbx_data_valid,
  input  logic [W_DATA-1:0] i_grbx_data,
  output logic              o_blk_valid,
  output logic [W_SYNC-1:0] o_blk_hdr,
  output logic [W_BLK-1:0]  o_blk_data,
  output logic              o_hdr_err,
`ifdef ETH_PCS_RX_ASM_ERR_CNT_EN
  output logic [15:0]       o_hdr_err_cnt,
  output logic [15:0]       o_seq_err_cnt,
`endif
  output logic              o_seq_err
);

  logic [W_DATA-1:0] descr_word;
  asm_state_t        state_q;
  logic [W_DATA-1:0] low_q;
  logic [W_SYNC-1:0] hdr_q;

  // Runs on every valid word independent of lock, so it is in sync when lock rises.
  eth_pcs_rx_descrambler #(
    .W (W_DATA)
  ) u_descrambler (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_grbx_data_valid),
    .i_data    (i_grbx_data),
    .o_data    (descr_word)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= WAIT_HDR;
      low_q       <= '0;
      hdr_q       <= '0;
      o_blk_valid <= 1'b0;
      o_blk_hdr   <= '0;
      o_blk_data  <= '0;
      o_hdr_err   <= 1'b0;
      o_seq_err   <= 1'b0;
    end else begin
      o_blk_valid <= 1'b0;
      o_hdr_err   <= 1'b0;
      o_seq_err   <= 1'b0;
      if (!i_rx_lock) begin
        // Lock loss silently abandons any half-built block.
        state_q <= WAIT_HDR;
      end else begin
        unique case (state_q)
          WAIT_HDR: begin
            if (i_grbx_hdr_valid && i_grbx_data_valid) begin
              low_q   <= descr_word;
              hdr_q   <= i_grbx_hdr;
              state_q <= HAVE_LOW;
            end
          end
          HAVE_LOW: begin
            if (i_grbx_data_valid && !i_grbx_hdr_valid) begin
              o_blk_valid <= 1'b1;
              o_blk_hdr   <= hdr_q;
              o_blk_data  <= {descr_word, low_q};
              o_hdr_err   <= hdr_is_bad(hdr_q);
              state_q     <= WAIT_HDR;
            end else if (i_grbx_data_valid && i_grbx_hdr_valid) begin
              // Early header: restart the block from this word.
              o_seq_err <= 1'b1;
              low_q     <= descr_word;
              hdr_q     <= i_grbx_hdr;
            end
          end
          default: state_q <= WAIT_HDR;
        endcase
      end
    end
  end

`ifdef ETH_PCS_RX_ASM_ERR_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_rx_lock) begin
      o_hdr_err_cnt <= '0;
      o_seq_err_cnt <= '0;
    end else begin
      if (o_hdr_err && o_blk_valid && (o_hdr_err_cnt != 16'hFFFF)) begin
        o_hdr_err_cnt <= o_hdr_err_cnt + 16'd1;
      end
      if (o_seq_err && (o_seq_err_cnt != 16'hFFFF)) begin
        o_seq_err_cnt <= o_seq_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_pcs_rx_block_assembler.sv
// Self-checking bench: bit-stream reference model plus directed and random stimulus.
module tb_eth_pcs_rx_block_assembler;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_rx_lock = 1'b0;
  logic        i_grbx_hdr_valid = 1'b0;
  logic [1:0]  i_grbx_hdr = 2'b00;
  logic        i_grbx_data_valid = 1'b0;
  logic [31:0] i_grbx_data = '0;
  logic        o_blk_valid;
  logic [1:0]  o_blk_hdr;
  logic [63:0] o_blk_data;
  logic        o_hdr_err;
  logic        o_seq_err;
`ifdef ETH_PCS_RX_ASM_ERR_CNT_EN
  logic [15:0] o_hdr_err_cnt;
  logic [15:0] o_seq_err_cnt;
`endif

  eth_pcs_rx_block_assembler dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .i_rx_lock         (i_rx_lock),
    .i_grbx_hdr_valid  (i_grbx_hdr_valid),
    .i_grbx_hdr        (i_grbx_hdr),
    .i_grbx_data_valid (i_grbx_data_valid),
    .i_grbx_data       (i_grbx_data),
    .o_blk_valid       (o_blk_valid),
    .o_blk_hdr         (o_blk_hdr),
    .o_blk_data        (o_blk_data),
    .o_hdr_err         (o_hdr_err),
`ifdef ETH_PCS_RX_ASM_ERR_CNT_EN
    .o_hdr_err_cnt     (o_hdr_err_cnt),
    .o_seq_err_cnt     (o_seq_err_cnt),
`endif
    .o_seq_err         (o_seq_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmit-side scrambler for directed tests: tx[n] = d[n] ^ tx[n-39] ^ tx[n-58], seed all ones.
  bit tx_hist[$];
  function automatic logic [31:0] scr(input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      w[i] = d[i] ^ tx_hist[$-38] ^ tx_hist[$-57];
      tx_hist.push_back(w[i]);
      void'(tx_hist.pop_front());
    end
    return w;
  endfunction

  // Reference model: received-bit history gives out[n] = rx[n] ^ rx[n-39] ^ rx[n-58].
  bit          rx_hist[$];
  bit          m_have_low;
  logic [31:0] m_low;
  logic [1:0]  m_hdr;
  logic        exp_valid, exp_seq, exp_herr;
  logic [1:0]  exp_hdr;
  logic [63:0] exp_data;
  bit          cmp_en = 0;

  function automatic logic [31:0] model_descr(input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      w[i] = d[i] ^ rx_hist[$-38] ^ rx_hist[$-57];
      rx_hist.push_back(d[i]);
      void'(rx_hist.pop_front());
    end
    return w;
  endfunction

  always @(posedge i_clk) begin
    logic [31:0] dw;
    if (!i_reset_n) begin
      rx_hist = {};
      for (int i = 0; i < 58; i++) rx_hist.push_back(1'b0);
      m_have_low = 0; m_low = '0; m_hdr = '0;
      exp_valid = 0; exp_seq = 0; exp_herr = 0; exp_hdr = '0; exp_data = '0;
    end else begin
      exp_valid = 0; exp_seq = 0; exp_herr = 0;
      dw = i_grbx_data_valid ? model_descr(i_grbx_data) : 32'h0;
      if (!i_rx_lock) begin
        m_have_low = 0;
      end else if (i_grbx_data_valid) begin
        if (i_grbx_hdr_valid) begin
          exp_seq = m_have_low;
          m_have_low = 1; m_low = dw; m_hdr = i_grbx_hdr;
        end else if (m_have_low) begin
          exp_valid = 1; exp_hdr = m_hdr; exp_data = {dw, m_low};
          exp_herr = (m_hdr == 2'b00) || (m_hdr == 2'b11);
          m_have_low = 0;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("blk_valid", {63'd0, o_blk_valid}, {63'd0, exp_valid});
      check("seq_err", {63'd0, o_seq_err}, {63'd0, exp_seq});
      check("hdr_err", {63'd0, o_hdr_err}, {63'd0, exp_herr});
      check("blk_hdr", {62'd0, o_blk_hdr}, {62'd0, exp_hdr});
      check("blk_data", o_blk_data, exp_data);
    end
  end

  task automatic cyc(input logic hv, input logic [1:0] h, input logic dv,
                     input logic [31:0] d, input logic lk);
    @(negedge i_clk);
    #1;
    i_grbx_hdr_valid = hv; i_grbx_hdr = h; i_grbx_data_valid = dv;
    i_grbx_data = d; i_rx_lock = lk;
  endtask

  task automatic settle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 58; i++) tx_hist.push_back(1'b1);
    i_reset_n = 1'b0;
    i_rx_lock = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", {63'd0, o_blk_valid}, 64'd0);
    check("rst_data", o_blk_data, 64'd0);
    check("rst_hdr", {62'd0, o_blk_hdr}, 64'd0);
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b1;
    cmp_en = 1;

    // Scrambled zero payload: block 1 is corrupted by the seed mismatch, later ones are clean.
    for (int b = 0; b < 3; b++) begin
      cyc(1'b1, 2'b01, 1'b1, scr(32'h0), 1'b1);
      cyc(1'b0, 2'b00, 1'b1, scr(32'h0), 1'b1);
      settle();
      check("dir_valid", {63'd0, o_blk_valid}, 64'd1);
      if (b > 0) begin
        check("dir_zero_data", o_blk_data, 64'h0);
        check("dir_hdr01", {62'd0, o_blk_hdr}, 64'd1);
      end
    end
    idle(2);

    // Gearbox skip cycle between the two halves.
    cyc(1'b1, 2'b01, 1'b1, scr(32'h0), 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 32'hDEAD_BEEF, 1'b1);
    settle();
    check("skip_no_valid", {63'd0, o_blk_valid}, 64'd0);
    cyc(1'b0, 2'b00, 1'b1, scr(32'h0), 1'b1);
    settle();
    check("skip_valid", {63'd0, o_blk_valid}, 64'd1);
    check("skip_seq", {63'd0, o_seq_err}, 64'd0);
    check("skip_data", o_blk_data, 64'h0);

    // Illegal header 2'b11.
    cyc(1'b1, 2'b11, 1'b1, scr(32'h0), 1'b1);
    cyc(1'b0, 2'b00, 1'b1, scr(32'h0), 1'b1);
    settle();
    check("bad_hdr_valid", {63'd0, o_blk_valid}, 64'd1);
    check("bad_hdr_err", {63'd0, o_hdr_err}, 64'd1);
    check("bad_hdr_val", {62'd0, o_blk_hdr}, 64'd3);

    // Header arrives where the high word was expected.
    cyc(1'b1, 2'b10, 1'b1, scr(32'h0), 1'b1);
    cyc(1'b1, 2'b01, 1'b1, scr(32'h0), 1'b1);
    settle();
    check("early_seq", {63'd0, o_seq_err}, 64'd1);
    check("early_no_valid", {63'd0, o_blk_valid}, 64'd0);
    cyc(1'b0, 2'b00, 1'b1, scr(32'h0), 1'b1);
    settle();
    check("early_next_valid", {63'd0, o_blk_valid}, 64'd1);
    check("early_next_hdr", {62'd0, o_blk_hdr}, 64'd1);
    check("early_next_data", o_blk_data, 64'h0);

    // Lock drop in HAVE_LOW; the descrambler keeps consuming words meanwhile.
    cyc(1'b1, 2'b01, 1'b1, scr(32'h0), 1'b1);
    cyc(1'b0, 2'b00, 1'b1, scr(32'h0), 1'b0);
    settle();
    check("lock_no_valid", {63'd0, o_blk_valid}, 64'd0);
    check("lock_no_seq", {63'd0, o_seq_err}, 64'd0);
    cyc(1'b0, 2'b00, 1'b1, scr(32'h0), 1'b1);
    settle();
    check("lock_orphan", {63'd0, o_blk_valid}, 64'd0);
    cyc(1'b1, 2'b10, 1'b1, scr(32'h0), 1'b1);
    cyc(1'b0, 2'b00, 1'b1, scr(32'h0), 1'b1);
    settle();
    check("lock_resume_valid", {63'd0, o_blk_valid}, 64'd1);
    check("lock_resume_data", o_blk_data, 64'h0);
    check("lock_resume_hdr", {62'd0, o_blk_hdr}, 64'd2);
    idle(2);

    // Random traffic, with occasional lock drops and resets, against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge i_clk);
      #1;
      i_reset_n         = ($urandom_range(0, 299) != 0);
      i_rx_lock         = ($urandom_range(0, 19) != 0);
      i_grbx_hdr_valid  = ($urandom_range(0, 2) == 0);
      i_grbx_hdr        = 2'($urandom_range(0, 3));
      i_grbx_data_valid = ($urandom_range(0, 5) != 0);
      i_grbx_data       = $urandom;
    end
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b1;
    idle(3);

`ifdef ETH_PCS_RX_ASM_ERR_CNT_EN
    for (int i = 0; i < 65540; i++) begin
      cyc(1'b1, 2'b00, 1'b1, $urandom, 1'b1);
      cyc(1'b0, 2'b00, 1'b1, $urandom, 1'b1);
    end
    idle(3);
    check("hdr_cnt_sat", {48'd0, o_hdr_err_cnt}, 64'hFFFF);
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b0;
    settle();
    check("hdr_cnt_rst", {48'd0, o_hdr_err_cnt}, 64'd0);
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b1;
    idle(2);
`endif

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_block_assembler.md
Name: eth_pcs_rx_block_assembler

Overview:
- Sits directly downstream of the RX gearbox and upstream of the 64b/66b decoder.
- Takes the gearbox's 32-bit data stream and its 2-bit sync header, descrambles the payload with the self-synchronising x^58+x^39+1 descrambler, and assembles two 32-bit words into one 66-bit block.
- Only blocks received while block lock is held are presented to the decoder.

Parameters:
- W_DATA, 32, width of one gearbox data word.
- W_SYNC, 2, sync header width.
- W_BLK, 64, block payload width; fixed at 2*W_DATA.
- W_SCR, 58, descrambler shift-register length.
- SCR_TAP, 39, second descrambler tap (x^39).

Ports:
- i_clk  in  1  core clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_rx_lock  in  1  block-lock status from the block sync.
- i_grbx_hdr_valid  in  1  header valid; coincides with the first (low) word of a block.
- i_grbx_hdr  in  W_SYNC  sync header.
- i_grbx_data_valid  in  1  data word valid.
- i_grbx_data  in  W_DATA  data word, LSB = first bit received.
- o_blk_valid  out  1  assembled block valid, one-cycle pulse.
- o_blk_hdr  out  W_SYNC  header of the block.
- o_blk_data  out  W_BLK  descrambled payload; bit 0 = first bit received.
- o_hdr_err  out  1  qualified by o_blk_valid; header is 2'b00 or 2'b11.
- o_seq_err  out  1  one-cycle pulse; block framing broken.

Behaviour:
- Reset values (i_reset_n low at a clock edge):
  - all outputs 0;
  - FSM in WAIT_HDR;
  - descrambler register all zeros;
  - partial-block buffer cleared.
- Descrambler:
  - Advances only when i_grbx_data_valid=1, and processes all 32 bits in that cycle.
  - For each bit i, in order 0..31: out = in ^ s[SCR_TAP-1] ^ s[W_SCR-1]; then s = {s[56:0], in}. The register shifts in the received (scrambled) bit.
  - Header bits never enter the descrambler.
  - The descrambler runs regardless of i_rx_lock, so it is already synchronised when lock rises.
- FSM states:
  - WAIT_HDR:
    - i_grbx_hdr_valid & i_grbx_data_valid & i_rx_lock → latch header and descrambled word into low half, go to HAVE_LOW.
    - i_grbx_data_valid without i_grbx_hdr_valid → word dropped, stay in WAIT_HDR.
    - i_grbx_hdr_valid without i_grbx_data_valid → header ignored, stay in WAIT_HDR.
  - HAVE_LOW:
    - i_grbx_data_valid & !i_grbx_hdr_valid → high half = descrambled word; next cycle o_blk_valid=1 with {high,low}, header and o_hdr_err; go to WAIT_HDR.
    - i_grbx_data_valid=0 (gearbox skip cycle) → hold, no output.
    - i_grbx_hdr_valid & i_grbx_data_valid (header arrives early) → o_seq_err pulse next cycle; partial block discarded; new header and word become the low half; stay in HAVE_LOW.
- Latency: o_blk_valid is asserted exactly 1 cycle after the high word is accepted.
- o_blk_hdr and o_blk_data hold their value until the next block.
- Lock loss: i_rx_lock=0 in any state forces WAIT_HDR next cycle; the partial block is discarded with no o_seq_err and no o_blk_valid.
- Reset mid-block: the partial block is lost and no output is produced.
- i_reset_n has priority over all other inputs.
- Gearbox slips appear as framing errors and are handled by the sequence-error path; they never stall the block.

Optional Feature:
- Macro: ETH_PCS_RX_ASM_ERR_CNT_EN.
- When defined:
  - Adds outputs o_hdr_err_cnt[15:0] and o_seq_err_cnt[15:0].
  - Each is a saturating counter (stops at 16'hFFFF), incremented on o_hdr_err&o_blk_valid and on o_seq_err respectively.
  - Both cleared by reset and while i_rx_lock=0.
- When not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (eth_pcs_params):
  - constants W_BLK, W_SCR, SCR_TAP;
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10;
  - FSM state enum typedef.
- W_DATA and W_SYNC already come from the shared packages.
- Sub-module eth_pcs_rx_descrambler:
  - W_DATA-wide, with i_valid, i_data, o_data and the 58-bit state;
  - reusable for a 64-bit datapath.

Test Plan:
- Lock=1; feed hdr 2'b01 with the 64'h0 payload scrambled by a reference scrambler (seed all-ones) for 3 blocks → from block 2 onward o_blk_data=64'h0, o_blk_hdr=2'b01, o_blk_valid pulses 1 cycle after each high word.
- Insert a data_valid=0 cycle between low and high words → block still emitted once, correct data, no o_seq_err.
- Header 2'b11 on a block → o_blk_valid=1, o_hdr_err=1, o_blk_hdr=2'b11.
- hdr_valid on the cycle the high word was expected → o_seq_err=1 pulse, no block for the broken one, next block correct.
- Drop i_rx_lock in HAVE_LOW for 1 cycle → no output, no o_seq_err; blocks resume after lock returns and a header arrives.
- With ETH_PCS_RX_ASM_ERR_CNT_EN: force 70000 bad headers → o_hdr_err_cnt saturates at 16'hFFFF; reset clears it to 0.
